// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared state encoding, line levels and sizing helper for uart_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Wide enough for up to 9 data bits and 2 stop bits.
  localparam int BIT_CNT_W = 4;

  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module   : baud_tick_gen
// Brief    : Free-running bit-period counter with synchronous clear; o_tick
//            marks the last cycle of each bit, o_pre_tick the cycle before.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick,
  output logic o_pre_tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_tick     = (cnt_q == CNT_MAX);
  assign o_pre_tick = (cnt_q == CNT_PRE);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : Valid/ready fed UART transmitter, LSB first, registered outputs.
// Options  : define UART_TX_PARITY_EN to insert a parity bit (PARITY_ODD).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e          state_q;
  uart_state_e          state_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [BIT_CNT_W-1:0] bit_cnt_d;
  logic                 tx_q;
  logic                 tx_d;
  logic                 in_ready_q;
  logic                 in_ready_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 tx_done_q;
  logic                 tx_done_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
  logic                 parity_d;
`endif

  logic tick;
  logic pre_tick;
  logic accept;
  logic last_next;

  // in_ready_q is only high in IDLE or the final stop cycle, so it alone
  // qualifies a transfer in both places.
  assign accept = in_valid && in_ready_q;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (accept),
    .o_tick     (tick),
    .o_pre_tick (pre_tick)
  );

  // Outputs are registered, so decide one cycle early whether the next
  // cycle is the final cycle of the last stop bit.
  assign last_next = (state_q == STOP) && pre_tick && (bit_cnt_q == LAST_STOP);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (accept) begin
      state_d   = START;
      shreg_d   = in_data;
      bit_cnt_d = '0;
      tx_d      = START_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_d  = (^in_data) ^ PARITY_ODD;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_d = LINE_IDLE;
        end
        START: begin
          if (tick) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            tx_d      = shreg_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
              state_d   = PARITY;
              tx_d      = parity_q;
`else
              state_d   = STOP;
              tx_d      = LINE_IDLE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
              shreg_d   = shreg_q >> 1;
              tx_d      = shreg_d[0];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_d   = STOP;
            bit_cnt_d = '0;
            tx_d      = LINE_IDLE;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_d   = IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            end
            tx_d = LINE_IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tx_d      = LINE_IDLE;
        end
      endcase
    end

    in_ready_d = (state_d == IDLE) || last_next;
    busy_d     = (state_d != IDLE);
    tx_done_d  = last_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tx_q       <= LINE_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx; cycle-exact scoreboard of the
//            expected line waveform plus per-scenario directed checks.
// Options  : define UART_TX_PARITY_EN to exercise the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;

  localparam int CLKS  = 4;
  localparam int DBITS = 8;
  localparam int SBITS = 1;
`ifdef UART_TX_PARITY_EN
  localparam bit PODD  = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  wire        in_ready;
  wire        tx;
  wire        busy;
  wire        tx_done;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_tx #(
    .CLKS_PER_BIT (CLKS),
    .DATA_BITS    (DBITS),
    .STOP_BITS    (SBITS)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD   (PODD)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  // One entry per clock cycle of an in-flight frame.
  typedef struct packed {
    logic tx;
    logic done;
    logic ready;
  } exp_t;

  exp_t sb_q[$];

  function automatic void push_frame(input logic [7:0] d);
    exp_t e;
    for (int i = 0; i < CLKS; i++) begin
      e.tx = 1'b0; e.done = 1'b0; e.ready = 1'b0;
      sb_q.push_back(e);
    end
    for (int b = 0; b < DBITS; b++) begin
      for (int i = 0; i < CLKS; i++) begin
        e.tx = d[b]; e.done = 1'b0; e.ready = 1'b0;
        sb_q.push_back(e);
      end
    end
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CLKS; i++) begin
      e.tx = (^d) ^ PODD; e.done = 1'b0; e.ready = 1'b0;
      sb_q.push_back(e);
    end
`endif
    for (int i = 0; i < SBITS * CLKS; i++) begin
      e.tx    = 1'b1;
      e.done  = (i == SBITS * CLKS - 1);
      e.ready = (i == SBITS * CLKS - 1);
      sb_q.push_back(e);
    end
  endfunction

  // Scoreboard: compares every cycle and loads a new frame on each transfer
  // the model itself predicts.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_busy;
    if (reset) begin
      sb_q.delete();
      e.tx = 1'b1; e.done = 1'b0; e.ready = 1'b1;
      exp_busy = 1'b0;
    end else if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      e.tx = 1'b1; e.done = 1'b0; e.ready = 1'b1;
      exp_busy = 1'b0;
    end
    checks += 4;
    if (tx !== e.tx) begin
      errors++; $display("FAIL sb_tx t=%0t got %b exp %b", $time, tx, e.tx);
    end
    if (tx_done !== e.done) begin
      errors++; $display("FAIL sb_tx_done t=%0t got %b exp %b", $time, tx_done, e.done);
    end
    if (in_ready !== e.ready) begin
      errors++; $display("FAIL sb_in_ready t=%0t got %b exp %b", $time, in_ready, e.ready);
    end
    if (busy !== exp_busy) begin
      errors++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy, exp_busy);
    end
    if (!reset && in_valid && e.ready) push_frame(in_data);
  end

  // Drives a byte and returns one #1 after the accepting edge.
  task automatic accept_byte(input logic [7:0] d, input bit keep_valid);
    logic ok;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) begin
        if (!keep_valid) in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    checks++; errors++;
    $display("FAIL accept_timeout data=%h got no in_ready exp in_ready=1", d);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL idle_timeout busy=%b exp 0", busy);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({tx, in_ready, busy, tx_done} !== 4'b1100) begin
        errors++;
        $display("FAIL reset_vals got tx/rdy/busy/done=%b exp 1100", {tx, in_ready, busy, tx_done});
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({tx, in_ready, busy, tx_done} !== 4'b1100) begin
        errors++;
        $display("FAIL post_reset_idle got tx/rdy/busy/done=%b exp 1100", {tx, in_ready, busy, tx_done});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single();
    int done_k = -1;
    int ndone  = 0;
    accept_byte(8'hA5, 1'b0);
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4) begin
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL a5_start k=%0d got %b exp 0", k, tx); end
      end
      if (k == 5) begin
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL a5_bit0 got %b exp 1", tx); end
      end
      if (k == 40) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy_end got %b exp 1", busy); end
      end
      if (k == 41) begin
        checks++;
        if ({busy, tx} !== 2'b01) begin errors++; $display("FAIL a5_after got busy/tx=%b exp 01", {busy, tx}); end
      end
      if (tx_done) begin ndone++; done_k = k; end
      @(posedge clk); #1;
    end
    checks++;
    if (done_k != 40 || ndone != 1) begin
      errors++; $display("FAIL a5_tx_done got k=%0d n=%0d exp k=40 n=1", done_k, ndone);
    end
  endtask

  task automatic test_back_to_back();
    int acc2 = -1;
    int d1   = -1;
    int d2   = -1;
    int nd   = 0;
    accept_byte(8'h00, 1'b1);
    in_data = 8'hFF;
    for (int k = 1; k <= 85; k++) begin
      @(negedge clk);
      if (tx_done) begin
        nd++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      if (in_ready && in_valid && acc2 < 0) acc2 = k;
      if (k == 41) begin
        checks++;
        if ({tx, busy} !== 2'b01) begin errors++; $display("FAIL b2b_second_start got tx/busy=%b exp 01", {tx, busy}); end
      end
      @(posedge clk); #1;
      if (acc2 == k) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (acc2 != 40) begin errors++; $display("FAIL b2b_accept2 got k=%0d exp 40", acc2); end
    checks++;
    if (d1 != 40 || d2 != 80 || nd != 2) begin
      errors++; $display("FAIL b2b_done got %0d,%0d n=%0d exp 40,80 n=2", d1, d2, nd);
    end
    wait_idle();
  endtask

  task automatic test_ignore();
    logic [7:0] rx = 8'h00;
    int early_rdy  = 0;
    accept_byte(8'h3C, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k < 40 && in_ready) early_rdy++;
      if (k == 40) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ign_final_ready got %b exp 1", in_ready); end
      end
      if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) rx[(k - 6) / 4] = tx;
      @(posedge clk); #1;
      if (k == 10) begin in_data = 8'hFF; in_valid = 1'b1; end
    end
    in_valid = 1'b0;
    checks++;
    if (early_rdy != 0) begin errors++; $display("FAIL ign_ready_low got %0d high cycles exp 0", early_rdy); end
    checks++;
    if (rx !== 8'h3C) begin errors++; $display("FAIL ign_payload got %h exp 3c", rx); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx = 8'h00;
    accept_byte(8'h55, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx, in_ready, busy, tx_done} !== 4'b1100) begin
      errors++; $display("FAIL mid_reset_async got tx/rdy/busy/done=%b exp 1100", {tx, in_ready, busy, tx_done});
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    accept_byte(8'h81, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) rx[(k - 6) / 4] = tx;
      @(posedge clk); #1;
    end
    checks++;
    if (rx !== 8'h81) begin errors++; $display("FAIL mid_next_payload got %h exp 81", rx); end
    wait_idle();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d = 8'h07;
    logic       exp_par;
    int         bad    = 0;
    int         done_k = -1;
    exp_par = (^d) ^ PODD;
    accept_byte(d, 1'b0);
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k >= 37 && k <= 40 && tx !== exp_par) bad++;
      if (tx_done) done_k = k;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL parity_bit got %0d wrong cycles exp 0 (bit %b)", bad, exp_par); end
    checks++;
    if (done_k != 44) begin errors++; $display("FAIL parity_frame_len got %0d exp 44", done_k); end
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
